// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data RAM geometry and the data-memory arbiter state encoding.
package cpu_pkg;

  localparam int CPU_AW = 10;
  localparam int CPU_DW = 32;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, debug/loader port, data-memory arbiter and data RAM.
interface dmem_arbiter_if #(
  parameter int AW = cpu_pkg::CPU_AW,
  parameter int DW = cpu_pkg::CPU_DW
);

  logic          cpu_req;
  logic          cpu_str;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_str;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_ack;

  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_str;
  logic [DW-1:0] ram_dout;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_str, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_str, dbg_addr, dbg_wdata, dbg_lock,
    input  ram_dout,
    output cpu_ack, cpu_stall, dbg_ack, rdata,
    output ram_addr, ram_din, ram_str
  );

  // Requesters plus RAM side.
  modport master (
    output cpu_req, cpu_str, cpu_addr, cpu_wdata,
    output dbg_req, dbg_str, dbg_addr, dbg_wdata, dbg_lock,
    output ram_dout,
    input  cpu_ack, cpu_stall, dbg_ack, rdata,
    input  ram_addr, ram_din, ram_str
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned   W   = 4,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register: holds at MAX once reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter for the single-port data RAM with starvation override and bounded debug burst lock.
// Optional DMEM_ARB_PERF_EN adds saturating stall and debug-grant counters.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW         = CPU_AW,
  parameter int DW         = CPU_DW,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic          clk,
  input  logic          reset,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]   cpu_stall_cnt,
  output logic [31:0]   dbg_grant_cnt,
`endif
  dmem_arbiter_if.slave bus
);

  localparam int WAIT_W = cnt_width(STARVE_MAX);
  localparam int LOCK_W = cnt_width(LOCK_MAX);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C  = WAIT_W'(STARVE_MAX);
  localparam logic [LOCK_W-1:0] LOCK_MAX_C  = LOCK_W'(LOCK_MAX);
  localparam logic [LOCK_W-1:0] LOCK_LAST_C = LOCK_W'(LOCK_MAX - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic [LOCK_W-1:0] w_lock_cnt;
  logic              w_dbg_prio;
  logic              w_dbg_gnt;
  logic              w_cpu_gnt;
  logic              w_dbg_wait;
  logic              w_cpu_stall;
  logic [AW-1:0]     w_ram_addr;
  logic [DW-1:0]     w_ram_din;

  // Arbitration state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant decision and next state; reset suppresses all grants so a pending store is dropped.
  always_comb begin
    w_dbg_prio  = 1'b0;
    w_dbg_gnt   = 1'b0;
    w_cpu_gnt   = 1'b0;
    w_state_nxt = NORMAL;
    case (r_state)
      NORMAL:  w_dbg_prio = (w_wait_cnt == WAIT_MAX_C);
      LOCKED:  w_dbg_prio = 1'b1;
      default: w_dbg_prio = 1'b0;
    endcase
    w_dbg_gnt = ~reset & bus.dbg_req & (w_dbg_prio | ~bus.cpu_req);
    w_cpu_gnt = ~reset & bus.cpu_req & ~w_dbg_gnt;
    case (r_state)
      NORMAL: begin
        if (w_dbg_gnt && bus.dbg_lock) w_state_nxt = LOCKED;
        else                           w_state_nxt = NORMAL;
      end
      LOCKED: begin
        // The grant that brings the burst to LOCK_MAX is the last locked one.
        if (w_dbg_gnt && bus.dbg_lock && (w_lock_cnt != LOCK_LAST_C)) w_state_nxt = LOCKED;
        else                                                            w_state_nxt = NORMAL;
      end
      default: w_state_nxt = NORMAL;
    endcase
  end

  assign w_dbg_wait  = bus.dbg_req & ~w_dbg_gnt;
  assign w_cpu_stall = bus.cpu_req & ~w_cpu_gnt;

  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX_C)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (~w_dbg_wait),
    .i_inc (w_dbg_wait),
    .o_cnt (w_wait_cnt)
  );

  sat_counter #(.W(LOCK_W), .MAX(LOCK_MAX_C)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_state_nxt == NORMAL),
    .i_inc (w_dbg_gnt),
    .o_cnt (w_lock_cnt)
  );

`ifdef DMEM_ARB_PERF_EN
  sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_cpu_stall),
    .o_cnt (cpu_stall_cnt)
  );

  sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_dbg_grant_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_dbg_gnt),
    .o_cnt (dbg_grant_cnt)
  );
`endif

  assign w_ram_addr = w_dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
  assign w_ram_din  = w_dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;

  assign bus.cpu_ack   = w_cpu_gnt;
  assign bus.cpu_stall = w_cpu_stall;
  assign bus.dbg_ack   = w_dbg_gnt;
  assign bus.rdata     = bus.ram_dout;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_din   = w_ram_din;
  assign bus.ram_str   = (w_cpu_gnt & bus.cpu_str) | (w_dbg_gnt & bus.dbg_str);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: grant patterns and load data go through scoreboard queues.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk;
  logic reset;
  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  logic [DW-1:0] mem [0:(1<<AW)-1];
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_stall_cnt;
  logic [31:0] dbg_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0]    exp_q[$];
  logic [DW-1:0] data_q[$];

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .LOCK_MAX(8)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef DMEM_ARB_PERF_EN
    .cpu_stall_cnt (cpu_stall_cnt),
    .dbg_grant_cnt (dbg_grant_cnt),
`endif
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM model: combinational read, store on rising edge.
  assign bus.ram_dout = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_str === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
  end

  task automatic set_cpu(input logic req, input logic str, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_str = str; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic str, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lock);
    bus.dbg_req = req; bus.dbg_str = str; bus.dbg_addr = a; bus.dbg_wdata = d; bus.dbg_lock = lock;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    #1;
    checks++;
    if ({bus.dbg_ack, bus.cpu_ack} !== 2'b00 || bus.ram_str !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle acks=%b ram_str=%b expected acks=00 ram_str=0", {bus.dbg_ack, bus.cpu_ack}, bus.ram_str);
    end
`ifdef DMEM_ARB_PERF_EN
    checks++;
    if (cpu_stall_cnt !== 32'd0 || dbg_grant_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf stall=%0d grants=%0d expected 0 0", cpu_stall_cnt, dbg_grant_cnt);
    end
`endif
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if ({bus.dbg_ack, bus.cpu_ack} !== 2'b00 || bus.ram_str !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle acks=%b ram_str=%b stall=%b expected 00 0 0",
               {bus.dbg_ack, bus.cpu_ack}, bus.ram_str, bus.cpu_stall);
    end
    tick();
  endtask

  task automatic test_cpu_only();
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] vals  [4];
    logic [DW-1:0] e;
    addrs[0] = 10'd0;   vals[0] = 32'd10;
    addrs[1] = 10'd1023; vals[1] = 32'hDEAD_BEEF;
    addrs[2] = 10'd5;   vals[2] = 32'd55;
    addrs[3] = 10'd301; vals[3] = 32'h0BAD_0301;
    for (int i = 0; i < 4; i++) begin
      set_cpu(1'b1, 1'b1, addrs[i], vals[i]);
      #1;
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.ram_str !== 1'b1 ||
          bus.ram_addr !== addrs[i] || bus.ram_din !== vals[i]) begin
        errors++;
        $display("FAIL cpu_store[%0d] ack=%b stall=%b str=%b addr=%0d din=%h expected 1 0 1 %0d %h",
                 i, bus.cpu_ack, bus.cpu_stall, bus.ram_str, bus.ram_addr, bus.ram_din, addrs[i], vals[i]);
      end
      tick();
      set_cpu(1'b1, 1'b0, addrs[i], '0);
      data_q.push_back(vals[i]);
      #1;
      checks++;
      if (bus.cpu_ack === 1'b1 && bus.cpu_stall === 1'b0 && bus.ram_str === 1'b0) begin
        e = data_q.pop_front();
        if (bus.rdata !== e) begin
          errors++;
          $display("FAIL cpu_load[%0d] rdata=%h expected %h", i, bus.rdata, e);
        end
      end else begin
        errors++;
        $display("FAIL cpu_load_ack[%0d] ack=%b stall=%b str=%b expected 1 0 0", i, bus.cpu_ack, bus.cpu_stall, bus.ram_str);
      end
      tick();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] e;
    set_cpu(1'b1, 1'b0, 10'd5, '0);
    set_dbg(1'b1, 1'b0, 10'd7, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back((i % 5 == 4) ? 2'b10 : 2'b01);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.dbg_ack, bus.cpu_ack} !== e || bus.cpu_stall !== e[1]) begin
        errors++;
        $display("FAIL starve_cycle[%0d] acks=%b stall=%b expected acks=%b stall=%b",
                 i, {bus.dbg_ack, bus.cpu_ack}, bus.cpu_stall, e, e[1]);
      end
      if (e[1]) begin
        checks++;
        if (bus.ram_addr !== 10'd7 || bus.ram_str !== 1'b0) begin
          errors++;
          $display("FAIL starve_dbg_mux[%0d] addr=%0d str=%b expected 7 0", i, bus.ram_addr, bus.ram_str);
        end
      end
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    checks++;
    if (cpu_stall_cnt !== 32'd4 || dbg_grant_cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf_counts stall=%0d grants=%0d expected 4 4", cpu_stall_cnt, dbg_grant_cnt);
    end
`endif
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic test_lock_burst();
    logic [1:0]    e;
    logic [DW-1:0] d;
    int k;
    k = 0;
    set_cpu(1'b1, 1'b0, 10'd5, '0);
    for (int c = 0; c < 21; c++) begin
      if (k < 12) set_dbg(1'b1, 1'b1, AW'(100 + k), DW'(32'h100 + k), 1'b1);
      else        set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
      exp_q.push_back((c < 4 || (c >= 12 && c < 16) || c == 20) ? 2'b01 : 2'b10);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.dbg_ack, bus.cpu_ack} !== e) begin
        errors++;
        $display("FAIL burst_cycle[%0d] acks=%b expected %b", c, {bus.dbg_ack, bus.cpu_ack}, e);
      end
      if (bus.dbg_ack === 1'b1) begin
        checks++;
        if (bus.ram_addr !== AW'(100 + k) || bus.ram_str !== 1'b1 || bus.ram_din !== DW'(32'h100 + k)) begin
          errors++;
          $display("FAIL burst_store[%0d] addr=%0d str=%b din=%h expected %0d 1 %h",
                   k, bus.ram_addr, bus.ram_str, bus.ram_din, 100 + k, 32'h100 + k);
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k !== 12) begin
      errors++;
      $display("FAIL burst_words acked=%0d expected 12", k);
    end
    set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      set_cpu(1'b1, 1'b0, AW'(100 + i), '0);
      data_q.push_back(DW'(32'h100 + i));
      #1;
      checks++;
      if (bus.cpu_ack === 1'b1) begin
        d = data_q.pop_front();
        if (bus.rdata !== d) begin
          errors++;
          $display("FAIL burst_readback[%0d] rdata=%h expected %h", i, bus.rdata, d);
        end
      end else begin
        errors++;
        $display("FAIL burst_readback_ack[%0d] ack=%b expected 1", i, bus.cpu_ack);
      end
      tick();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_lock_drop();
    logic [1:0] e;
    int k;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      set_cpu((c >= 1) ? 1'b1 : 1'b0, 1'b0, 10'd5, '0);
      if (k < 3) set_dbg(1'b1, 1'b1, AW'(200 + k), DW'(k), (k < 2) ? 1'b1 : 1'b0);
      else       set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
      exp_q.push_back((c < 3) ? 2'b10 : 2'b01);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.dbg_ack, bus.cpu_ack} !== e || bus.cpu_stall !== ((c >= 1) && e[1])) begin
        errors++;
        $display("FAIL lockdrop_cycle[%0d] acks=%b stall=%b expected acks=%b stall=%b",
                 c, {bus.dbg_ack, bus.cpu_ack}, bus.cpu_stall, e, (c >= 1) && e[1]);
      end
      if (bus.dbg_ack === 1'b1) k++;
      tick();
    end
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL lockdrop_words acked=%0d expected 3", k);
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid_lock();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b1, 1'b1, 10'd300, 32'h0000_1234, 1'b1);
    #1;
    checks++;
    if ({bus.dbg_ack, bus.cpu_ack} !== 2'b10) begin
      errors++;
      $display("FAIL rst_lock_enter acks=%b expected 10", {bus.dbg_ack, bus.cpu_ack});
    end
    tick();
    set_dbg(1'b1, 1'b1, 10'd301, 32'h0000_5678, 1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.dbg_ack, bus.cpu_ack} !== 2'b00 || bus.ram_str !== 1'b0) begin
      errors++;
      $display("FAIL rst_during acks=%b ram_str=%b expected 00 0", {bus.dbg_ack, bus.cpu_ack}, bus.ram_str);
    end
    tick();
    reset = 1'b0;
    set_cpu(1'b1, 1'b0, 10'd5, '0);
    #1;
    checks++;
    if ({bus.dbg_ack, bus.cpu_ack} !== 2'b01) begin
      errors++;
      $display("FAIL rst_after_cpu acks=%b expected 01", {bus.dbg_ack, bus.cpu_ack});
    end
    checks++;
    if (mem[301] !== 32'h0BAD_0301) begin
      errors++;
      $display("FAIL rst_store_dropped mem301=%h expected 0bad0301", mem[301]);
    end
    tick();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b1, 1'b1, 10'd301, 32'h0000_5678, 1'b0);
    #1;
    checks++;
    if ({bus.dbg_ack, bus.cpu_ack} !== 2'b10) begin
      errors++;
      $display("FAIL rst_dbg_retry acks=%b expected 10", {bus.dbg_ack, bus.cpu_ack});
    end
    tick();
    set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (mem[301] !== 32'h0000_5678 || mem[300] !== 32'h0000_1234) begin
      errors++;
      $display("FAIL rst_dbg_stores mem300=%h mem301=%h expected 00001234 00005678", mem[300], mem[301]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_starvation();
    test_lock_burst();
    test_lock_drop();
    test_reset_mid_lock();
    checks++;
    if (data_q.size() !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain data_left=%0d grants_left=%0d expected 0 0", data_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
